vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

Raster scan generator for the 640x480@60 Hz display path. Divides the system clock down to a pixel rate and produces the 10-bit horizontal/vertical pixel coordinates, active-low sync pulses and a visible-area flag. It feeds the downstream 10-bit magnitude comparators that decide per-pixel drawing regions. It also drives the VGA connector sync pins directly.

## Interface
- `CLK_DIV`, 4: system clocks per pixel, at least 1. 100 MHz / 4 gives 25 MHz.
- `H_VISIBLE`, `H_FP`, `H_SYNC`, `H_BP`: 640, 16, 96, 48. Horizontal timing in pixels.
- `V_VISIBLE`, `V_FP`, `V_SYNC`, `V_BP`: 480, 10, 2, 33. Vertical timing in lines.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; low freezes the block.
- `hcount`  out  10  current pixel column, 0..H_TOTAL-1.
- `vcount`  out  10  current line, 0..V_TOTAL-1.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `active`  out  1  high when the current pixel is in the visible area.
- `pix_stb`  out  1  one-clk pulse in the first clk cycle of each new pixel.
- `frame_start`  out  1  one-clk pulse, coincident with `pix_stb`, when the counts become (0,0).

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be at most 1024; an elaboration check flags violations.
- Divider: `tick_cnt` counts 0..CLK_DIV-1 while `en`=1. An internal tick is asserted when `tick_cnt`==CLK_DIV-1. With CLK_DIV=1 the tick is asserted every enabled cycle.
- On each tick:
  - `hcount` increments.
  - At H_TOTAL-1, `hcount` wraps to 0 and `vcount` increments.
  - `vcount` wraps from V_TOTAL-1 to 0.
- `hsync`/`vsync`/`active` are registered. They are computed from the next count values, so they are always aligned with the `hcount`/`vcount` currently on the outputs:
  - `hsync` = 0 iff H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - `vsync` = 0 iff 490 <= vcount <= 491.
  - `active` = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
- `pix_stb` is registered from the tick. `frame_start` is registered from (tick && next counts == 0,0).
- `en`=0:
  - Divider, counters and sync/active outputs hold their values.
  - `pix_stb` and `frame_start` are 0.
  - `tick_cnt` holds, so timing resumes exactly where it stopped.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `tick_cnt`=0, `hcount`=799, `vcount`=524.
  - `hsync`=1, `vsync`=1, `active`=0.
  - `pix_stb`=0, `frame_start`=0.
- After reset, the first tick moves the counts to (0,0) and asserts `frame_start`.
- Pixel cadence: with `en` held high from reset release, counts change on the CLK_DIV-th rising edge and every CLK_DIV edges after that.
- `pix_stb` is high for exactly the one clk following each count change.
- Latency: all outputs change on the same edge as the counts. There is zero relative skew between coordinates and sync/active.
- Wrap cases:
  - (799, v) goes to (0, v+1).
  - (799, 524) goes to (0, 0) with `frame_start`=1.
  - Sync transitions occur on the edge where the count enters or leaves the sync window.
- Reset asserted mid-frame: all outputs go to reset values immediately, not waiting for a clock edge. Release restarts from the reset state with no partial-pixel tick.
- `en` deasserted on the same cycle as a tick: the tick is suppressed. The count advances on the first enabled tick edge instead.

## Structure
- Shared package `vga_timing_pkg`: the default H_*/V_* constants, H_TOTAL/V_TOTAL, and the counter width (10). The downstream comparator stage uses the same constants.
- One sub-module, `pixel_tick_gen`:
  - Parameter CLK_DIV; inputs `clk`, `rst_n`, `en`; output `tick`.
  - Owns `tick_cnt`.
- The top level holds the H/V counters and the output registers.

## Test plan
- Reset: hold `rst_n`=0 for 5 clks. Outputs read 799/524, hsync=1, vsync=1, active=0, strobes 0. Release: the 4th edge gives (0,0), active=1, frame_start=1, pix_stb=1 the next cycle.
- Cadence (CLK_DIV=4): over 40 clks, `pix_stb` pulses exactly 10 times, 4 clks apart, and hcount advances 0 to 10.
- Horizontal sync: on line 0, hsync falls as hcount becomes 656 and rises at 752. active falls as hcount becomes 640. At 799 to 0, vcount goes 0 to 1.
- Frame wrap: run to (799,524) and tick. Counts become (0,0) with frame_start=1 for one clk. vsync is low exactly while vcount is 490..491.
- Enable hold: at (100,20), drop `en` for 37 clks. Outputs are frozen and strobes stay 0. After re-enable, the remaining divider phase is preserved: the next change occurs at the same phase as without the stall.
- Async reset mid-frame: at (300,200), pulse `rst_n` low between clock edges. Outputs go to reset values without a clock edge. Recovery matches the first scenario.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 raster timing constants
// Contents:
//   CNT_W            coordinate width (10 bits)
//   VGA_H_* / VGA_V_* default horizontal (pixels) / vertical (lines) timing
//   VGA_H_TOTAL/V_TOTAL  full line / frame lengths
//   coord_t, wide_t  coordinate type and one-bit-wider compare type
//   in_window()      half-open range test lo <= val < hi
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [CNT_W-1:0] coord_t;
  // One extra bit so window ends equal to 1024 remain representable.
  typedef logic [CNT_W:0]   wide_t;

  function automatic logic in_window(input wide_t val, input wide_t lo, input wide_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - system-clock to pixel-rate tick divider
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   run enable; low holds the divider phase
//   tick   out  high in the enabled cycle where tick_cnt == CLK_DIV-1
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_div_chk
    $error("pixel_tick_gen: CLK_DIV must be at least 1");
  end

  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;

  // Combinational so the top can advance its counters on the same edge
  // the divider wraps; en gates it so a stalled cycle never ticks.
  assign tick = en && (tick_cnt_q == LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick) begin
      tick_cnt_d = '0;
    end else if (en) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - raster scan generator (coordinates, syncs, visible flag)
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable; low freezes everything, strobes read 0
//   hcount       out  current pixel column, 0..H_TOTAL-1
//   vcount       out  current line, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   active       out  current pixel lies in the visible area
//   pix_stb      out  one-clk pulse in the first cycle of each pixel
//   frame_start  out  one-clk pulse when the counts become (0,0)
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             pix_stb,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_chk
    $error("vga_scan_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_chk
    $error("vga_scan_gen: V_TOTAL exceeds counter range");
  end

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam wide_t  H_VIS  = wide_t'(H_VISIBLE);
  localparam wide_t  V_VIS  = wide_t'(V_VISIBLE);
  localparam wide_t  HS_LO  = wide_t'(H_VISIBLE + H_FP);
  localparam wide_t  HS_HI  = wide_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam wide_t  VS_LO  = wide_t'(V_VISIBLE + V_FP);
  localparam wide_t  VS_HI  = wide_t'(V_VISIBLE + V_FP + V_SYNC);

  logic tick;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  coord_t hcount_q, hcount_d;
  coord_t vcount_q, vcount_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   active_q, active_d;
  logic   pix_stb_q, pix_stb_d;
  logic   frame_start_q, frame_start_d;

  // Decodes use the next counts so sync/active land on the same edge as
  // the coordinates they describe. Without a tick the next counts equal
  // the current ones, so the decodes simply hold.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end

    hsync_d       = !in_window({1'b0, hcount_d}, HS_LO, HS_HI);
    vsync_d       = !in_window({1'b0, vcount_d}, VS_LO, VS_HI);
    active_d      = ({1'b0, hcount_d} < H_VIS) && ({1'b0, vcount_d} < V_VIS);
    pix_stb_d     = tick;
    frame_start_d = tick && (hcount_d == '0) && (vcount_d == '0);
  end

  // Reset parks the counts on the last pixel of the frame so the first
  // tick wraps to (0,0) and raises frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      pix_stb_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pix_stb_q     <= pix_stb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign pix_stb     = pix_stb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - directed self-checking bench for vga_scan_gen
module tb_vga_scan_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [9:0] hcount, vcount;
  logic       hsync, vsync, active, pix_stb, frame_start;

  logic       rst_s;
  logic [9:0] s_h, s_v;
  logic       s_hs, s_vs, s_act, s_stb, s_fs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_scan_gen u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .active(active), .pix_stb(pix_stb), .frame_start(frame_start)
  );

  // Shrunk timing with CLK_DIV=1 so a full frame wrap fits in a short run:
  // H 8+2+3+3=16 (hsync 10..12), V 6+2+2+3=13 (vsync lines 8..9).
  vga_scan_gen #(
    .CLK_DIV(1),
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .clk(clk), .rst_n(rst_s), .en(1'b1),
    .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .active(s_act), .pix_stb(s_stb), .frame_start(s_fs)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_h"}, int'(hcount), 799);
    chk({tag, "_v"}, int'(vcount), 524);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_stb"}, int'(pix_stb), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
  endtask

  // Startup after a reset release made at a falling edge: three edges of
  // divider phase, then (0,0) with both strobes on the fourth edge.
  task automatic chk_recovery(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_pre_h"}, int'(hcount), 799);
    chk({tag, "_pre_stb"}, int'(pix_stb), 0);
    @(negedge clk);
    chk({tag, "_h"}, int'(hcount), 0);
    chk({tag, "_v"}, int'(vcount), 0);
    chk({tag, "_active"}, int'(active), 1);
    chk({tag, "_fs"}, int'(frame_start), 1);
    chk({tag, "_stb"}, int'(pix_stb), 1);
    @(negedge clk);
    chk({tag, "_stb_off"}, int'(pix_stb), 0);
    chk({tag, "_fs_off"}, int'(frame_start), 0);
  endtask

  // Returns at the falling edge where (h,v) has just been entered.
  task automatic wait_px(input int h, input int v, input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if (int'(hcount) == h && int'(vcount) == v && pix_stb) hit = 1'b1;
    end
    chk($sformatf("reach_%0d_%0d", h, v), int'(hit), 1);
  endtask

  initial begin
    int pulses, last, gap_ok, froze, eh, ev;

    rst_n = 1'b0;
    rst_s = 1'b0;
    en    = 1'b1;

    // Reset state
    repeat (5) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;
    chk_recovery("start");

    // Cadence: 40 clocks, ten strobes exactly four apart
    pulses = 0; last = -1; gap_ok = 1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (pix_stb) begin
        pulses++;
        if (last >= 0 && c - last != 4) gap_ok = 0;
        last = c;
      end
    end
    chk("cad_pulses", pulses, 10);
    chk("cad_gap", gap_ok, 1);
    chk("cad_h", int'(hcount), 10);

    // Horizontal edges on line 0
    wait_px(639, 0, 3000);
    chk("act_639", int'(active), 1);
    wait_px(640, 0, 8);
    chk("act_640", int'(active), 0);
    wait_px(655, 0, 100);
    chk("hs_655", int'(hsync), 1);
    wait_px(656, 0, 8);
    chk("hs_656", int'(hsync), 0);
    wait_px(751, 0, 400);
    chk("hs_751", int'(hsync), 0);
    wait_px(752, 0, 8);
    chk("hs_752", int'(hsync), 1);
    wait_px(799, 0, 200);
    wait_px(0, 1, 8);
    chk("line1_active", int'(active), 1);
    chk("line1_fs", int'(frame_start), 0);

    // Enable hold at (100,2) with two divider steps already taken
    wait_px(100, 2, 4000);
    repeat (2) @(negedge clk);
    en = 1'b0;
    froze = 1;
    repeat (37) begin
      @(negedge clk);
      if (hcount != 10'd100 || vcount != 10'd2 || pix_stb || frame_start || !active)
        froze = 0;
    end
    chk("hold_frozen", froze, 1);
    en = 1'b1;
    @(negedge clk);
    chk("resume_h_early", int'(hcount), 100);
    @(negedge clk);
    chk("resume_h", int'(hcount), 101);
    chk("resume_stb", int'(pix_stb), 1);

    // en low exactly in the tick cycle: that tick is lost
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("sup_h", int'(hcount), 101);
    chk("sup_stb", int'(pix_stb), 0);
    en = 1'b1;
    @(negedge clk);
    chk("sup_resume_h", int'(hcount), 102);
    chk("sup_resume_stb", int'(pix_stb), 1);

    // Asynchronous reset between clock edges
    wait_px(300, 2, 1000);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    chk_recovery("arst_rec");

    // Small instance (CLK_DIV=1): startup, then one full frame to the wrap
    rst_s = 1'b1;
    @(negedge clk);
    chk("s_start_h", int'(s_h), 0);
    chk("s_start_v", int'(s_v), 0);
    chk("s_start_fs", int'(s_fs), 1);
    chk("s_start_stb", int'(s_stb), 1);
    eh = 0; ev = 0;
    for (int c = 0; c < 16 * 13; c++) begin
      @(negedge clk);
      eh++;
      if (eh == 16) begin
        eh = 0;
        ev = (ev == 12) ? 0 : ev + 1;
      end
      chk("s_h", int'(s_h), eh);
      chk("s_v", int'(s_v), ev);
      chk("s_hsync", int'(s_hs), (eh >= 10 && eh <= 12) ? 0 : 1);
      chk("s_vsync", int'(s_vs), (ev >= 8 && ev <= 9) ? 0 : 1);
      chk("s_active", int'(s_act), (eh < 8 && ev < 6) ? 1 : 0);
      chk("s_fs", int'(s_fs), (eh == 0 && ev == 0) ? 1 : 0);
      chk("s_stb", int'(s_stb), 1);
    end
    @(negedge clk);
    chk("s_fs_after_wrap", int'(s_fs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
